fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
// - Issue-side initiator for the FPU arithmetic unit: accepts one FP op from the integer pipeline (valid/ready),
//   resolves dynamic rounding, drives start/op/rm/operands, holds them until done, captures the result and flags.
// - Writes back with valid/ready and keeps the sticky fflags (NV,DZ,OF,UF,NX) that the CSR file reads/writes.
// - Sits between decode/execute and the FPU arithmetic unit; exactly one op in flight.
// PARAMETERS
// - TIMEOUT_CYCLES  64  max BUSY cycles without fu_done before abort with wb_err
// - CNT_W  $clog2(TIMEOUT_CYCLES+1)  width of the busy-cycle counter (derived, not overridden)
// PORTS
// - clk  in  1  clock, rising edge
// - reset  in  1  asynchronous, active-low reset (0 = reset)
// - req_valid/req_ready  in/out  1/1  request handshake; transfer when both are 1 on a rising edge
// - req_op  in  5  FPU op code (FADD 00000, FSUB 00001, FMUL 00010, FDIV 00011, FSQRT 01011, FSGNJ 00100, MINMAX 00101,
//   CVT.W 11000, CVT.S 11010, CMP 10100, CLASS/MV 11100, MV.W.X 11110)
// - req_rm  in  3  instruction rm/funct3; req_rs2_lsb  in  1  signedness select for conversions
// - req_a, req_b  in  32  operands; req_rd  in  5  destination register index
// - frm  in  3  CSR dynamic rounding mode
// - fu_start  out  1; fu_op  out  5; fu_rm  out  3; fu_a, fu_b  out  32; fu_rs2_lsb  out  1  drive to the arithmetic unit
// - fu_result  in  32; fu_done  in  1; fu_of, fu_uf, fu_nv, fu_nx, fu_dz  in  1 each  returned from the arithmetic unit
// - wb_valid/wb_ready  out/in  1/1  writeback handshake; wb_data  out  32; wb_rd  out  5
// - wb_to_int  out  1  destination is an integer register (CVT.W, CMP, CLASS, FMV.X.W)
// - wb_err  out  1  result is invalid: illegal rm or timeout; wb_data = 0 and no flags accrued
// - fflags  out  5  sticky {NV,DZ,OF,UF,NX}; fflags_we  in  1; fflags_wdata  in  5  CSR write
// BEHAVIOUR
// - Reset values: state IDLE, req_ready=1, fu_start=0, all fu_* outputs 0, wb_valid=0, wb_data=0, wb_rd=0,
//   wb_to_int=0, wb_err=0, fflags=0, counter=0.
// - Register outputs use asynchronous reset. Asserting reset mid-operation discards the op. fflags are not updated.
// - FSM IDLE -> BUSY on req handshake: latch op, rs2_lsb, a, b, rd and the effective rm.
// - Effective rm for arithmetic ops (add, sub, mul, div, sqrt, cvt): req_rm==111 selects frm. Other ops pass req_rm unchanged.
// - Illegal rounding: effective rm of 101/110/111 on an arithmetic op goes IDLE -> WB directly, with wb_err=1 and fu_start kept 0.
// - BUSY: fu_start=1, fu_* held stable. On the first cycle with fu_done=1, capture fu_result and the flags and go to WB.
//   fu_done is ignored whenever fu_start=0.
// - Single-cycle ops: one BUSY cycle, then WB. Request to wb_valid latency is 2 cycles.
// - BUSY counter increments each cycle. On reaching TIMEOUT_CYCLES with no done, go to WB with wb_err=1.
// - WB: fu_start=0, so the unit sees start drop for at least one cycle. wb_valid=1 with data, rd and to_int stable.
//   On wb_ready go to IDLE. Hold indefinitely while wb_ready=0.
// - req_ready=1 only in IDLE. No bypass of a new request during the WB handshake cycle.
// - fflags accrue (OR) in the cycle the WB handshake completes, and only when wb_err=0.
// - fflags_we overrides that cycle's accrual: fflags <= fflags_wdata. Accrual is lost only if it lands in the same
//   cycle as the CSR write.
// STRUCTURE
// - Shared package fpu_pkg: op code localparams, rm encodings (RNE..RMM, DYN=111), FFLAG bit indices, state enum.
// - Single module. No sub-module needed; the timeout counter is inline.
// TESTING
// - FADD: a=0x3F800000, b=0x40000000, rm=000, done same cycle -> wb_data=0x40400000 two cycles after req, fflags=0.
// - FDIV: 1.0 / +0 with done after 20 cycles -> fu_start high exactly 20 cycles, wb_data=0x7F800000, fflags=5'b01000.
// - req_rm=111 with frm=101 on FMUL -> no fu_start pulse, wb_err=1, fflags unchanged. Same op with frm=001 -> fu_rm=001.
// - Backpressure: hold wb_ready=0 for 5 cycles -> wb_valid, wb_data and wb_rd stable; req_ready=0; fflags update only on handshake.
// - Assert reset in BUSY cycle 3 of FSQRT -> next edge IDLE, fu_start=0, wb_valid=0, fflags=0.
// - fu_done never asserted -> wb_err=1 after 64 BUSY cycles. fflags_we pulse at handshake with wdata=0 -> fflags=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue path: op codes, rounding modes, flag bits, FSM states.
package fpu_pkg;

    localparam logic [4:0] OP_FADD   = 5'b00000;
    localparam logic [4:0] OP_FSUB   = 5'b00001;
    localparam logic [4:0] OP_FMUL   = 5'b00010;
    localparam logic [4:0] OP_FDIV   = 5'b00011;
    localparam logic [4:0] OP_FSQRT  = 5'b01011;
    localparam logic [4:0] OP_FSGNJ  = 5'b00100;
    localparam logic [4:0] OP_MINMAX = 5'b00101;
    localparam logic [4:0] OP_CVT_W  = 5'b11000;
    localparam logic [4:0] OP_CVT_S  = 5'b11010;
    localparam logic [4:0] OP_CMP    = 5'b10100;
    localparam logic [4:0] OP_CLASS  = 5'b11100;
    localparam logic [4:0] OP_MV_W_X = 5'b11110;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Ops whose result depends on the rounding mode.
    function automatic logic is_arith(input logic [4:0] op);
        return op == OP_FADD || op == OP_FSUB || op == OP_FMUL || op == OP_FDIV ||
               op == OP_FSQRT || op == OP_CVT_W || op == OP_CVT_S;
    endfunction

    function automatic logic is_to_int(input logic [4:0] op);
        return op == OP_CVT_W || op == OP_CMP || op == OP_CLASS;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the FPU arithmetic unit: one op in flight, rounding resolution,
// timeout abort, writeback handshake and sticky fflags.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic        req_rs2_lsb,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  frm,
    output logic        fu_start,
    output logic [4:0]  fu_op,
    output logic [2:0]  fu_rm,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    output logic        fu_rs2_lsb,
    input  logic [31:0] fu_result,
    input  logic        fu_done,
    input  logic        fu_of,
    input  logic        fu_uf,
    input  logic        fu_nv,
    input  logic        fu_nx,
    input  logic        fu_dz,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_to_int,
    output logic        wb_err,
    output logic [4:0]  fflags,
    input  logic        fflags_we,
    input  logic [4:0]  fflags_wdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [4:0]       flags_q;
    logic             arith;
    logic [2:0]       eff_rm;
    logic             rm_bad;
    logic             wb_hs;

    always_comb begin
        arith   = is_arith(req_op);
        eff_rm  = (arith && req_rm == RM_DYN) ? frm : req_rm;
        rm_bad  = arith && (eff_rm > RM_RMM);
        cnt_nxt = cnt + 1'b1;
        wb_hs   = wb_valid && wb_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            fu_start   <= 1'b0;
            fu_op      <= '0;
            fu_rm      <= '0;
            fu_a       <= '0;
            fu_b       <= '0;
            fu_rs2_lsb <= 1'b0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_to_int  <= 1'b0;
            wb_err     <= 1'b0;
            flags_q    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        fu_op      <= req_op;
                        fu_rm      <= eff_rm;
                        fu_a       <= req_a;
                        fu_b       <= req_b;
                        fu_rs2_lsb <= req_rs2_lsb;
                        wb_rd      <= req_rd;
                        wb_to_int  <= is_to_int(req_op);
                        req_ready  <= 1'b0;
                        cnt        <= '0;
                        // Illegal rounding never reaches the unit.
                        if (rm_bad) begin
                            state    <= ST_WB;
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_data  <= '0;
                            flags_q  <= '0;
                        end else begin
                            state    <= ST_BUSY;
                            fu_start <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (fu_done) begin
                        state    <= ST_WB;
                        fu_start <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b0;
                        wb_data  <= fu_result;
                        flags_q  <= {fu_nv, fu_dz, fu_of, fu_uf, fu_nx};
                    end else if (cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                        state    <= ST_WB;
                        fu_start <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_data  <= '0;
                        flags_q  <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state     <= ST_IDLE;
                        wb_valid  <= 1'b0;
                        wb_err    <= 1'b0;
                        req_ready <= 1'b1;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    fu_start  <= 1'b0;
                    wb_valid  <= 1'b0;
                end
            endcase
        end
    end

    // A CSR write in the handshake cycle wins over the accrual.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags <= '0;
        end else if (fflags_we) begin
            fflags <= fflags_wdata;
        end else if (wb_hs && !wb_err) begin
            fflags <= fflags | flags_q;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; the bench plays the arithmetic unit and drives done/flags itself.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rs2_lsb;
    logic [4:0]  req_op, req_rd;
    logic [2:0]  req_rm, frm;
    logic [31:0] req_a, req_b;
    logic        fu_start, fu_rs2_lsb;
    logic [4:0]  fu_op;
    logic [2:0]  fu_rm;
    logic [31:0] fu_a, fu_b, fu_result;
    logic        fu_done, fu_of, fu_uf, fu_nv, fu_nx, fu_dz;
    logic        wb_valid, wb_ready, wb_to_int, wb_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd, fflags, fflags_wdata;
    logic        fflags_we;

    int chk = 0;
    int pass = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
        .req_rs2_lsb(req_rs2_lsb), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .frm(frm),
        .fu_start(fu_start), .fu_op(fu_op), .fu_rm(fu_rm), .fu_a(fu_a), .fu_b(fu_b),
        .fu_rs2_lsb(fu_rs2_lsb), .fu_result(fu_result), .fu_done(fu_done),
        .fu_of(fu_of), .fu_uf(fu_uf), .fu_nv(fu_nv), .fu_nx(fu_nx), .fu_dz(fu_dz),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_to_int(wb_to_int), .wb_err(wb_err),
        .fflags(fflags), .fflags_we(fflags_we), .fflags_wdata(fflags_wdata)
    );

    // Presents a request at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
        req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic set_fu(input logic d, input logic [31:0] r, input logic [4:0] f);
        fu_done = d; fu_result = r;
        {fu_nv, fu_dz, fu_of, fu_uf, fu_nx} = f;
    endtask

    task automatic test_reset;
        chk++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", req_ready); else pass++;
        chk++; if (fu_start !== 1'b0) $display("FAIL rst_fu_start got %b exp 0", fu_start); else pass++;
        chk++; if ({fu_op, fu_rm, fu_a, fu_b} !== '0) $display("FAIL rst_fu_outs got %h exp 0", {fu_op, fu_rm, fu_a, fu_b}); else pass++;
        chk++; if (wb_valid !== 1'b0 || wb_err !== 1'b0 || wb_to_int !== 1'b0) $display("FAIL rst_wb_ctl got %b%b%b exp 000", wb_valid, wb_err, wb_to_int); else pass++;
        chk++; if (wb_data !== 32'h0 || wb_rd !== 5'h0) $display("FAIL rst_wb_data got %h/%h exp 0/0", wb_data, wb_rd); else pass++;
        chk++; if (fflags !== 5'b0) $display("FAIL rst_fflags got %b exp 00000", fflags); else pass++;
    endtask

    task automatic test_fadd;
        send(5'b00000, 3'b000, 32'h3F800000, 32'h40000000, 5'd3);
        chk++; if (fu_start !== 1'b1 || req_ready !== 1'b0) $display("FAIL fadd_busy got start=%b ready=%b exp 1/0", fu_start, req_ready); else pass++;
        chk++; if (fu_op !== 5'b00000 || fu_rm !== 3'b000 || fu_a !== 32'h3F800000 || fu_b !== 32'h40000000)
            $display("FAIL fadd_fu_outs got op=%b rm=%b a=%h b=%h", fu_op, fu_rm, fu_a, fu_b); else pass++;
        set_fu(1'b1, 32'h40400000, 5'b0);
        @(negedge clk);
        set_fu(1'b0, 32'h0, 5'b0);
        chk++; if (wb_valid !== 1'b1 || fu_start !== 1'b0) $display("FAIL fadd_latency got valid=%b start=%b exp 1/0", wb_valid, fu_start); else pass++;
        chk++; if (wb_data !== 32'h40400000 || wb_rd !== 5'd3 || wb_err !== 1'b0 || wb_to_int !== 1'b0)
            $display("FAIL fadd_wb got data=%h rd=%0d err=%b int=%b exp 40400000/3/0/0", wb_data, wb_rd, wb_err, wb_to_int); else pass++;
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk++; if (wb_valid !== 1'b0 || req_ready !== 1'b1 || fflags !== 5'b0)
            $display("FAIL fadd_done got valid=%b ready=%b fflags=%b exp 0/1/00000", wb_valid, req_ready, fflags); else pass++;
    endtask

    task automatic test_fdiv;
        int hi = 0;
        send(5'b00011, 3'b000, 32'h3F800000, 32'h00000000, 5'd7);
        for (int i = 1; i <= 20; i++) begin
            if (fu_start) hi++;
            if (i == 20) set_fu(1'b1, 32'h7F800000, 5'b01000);
            @(negedge clk);
        end
        set_fu(1'b0, 32'h0, 5'b0);
        for (int i = 0; i < 5; i++) begin
            if (fu_start) hi++;
            @(negedge clk);
        end
        chk++; if (hi !== 20) $display("FAIL fdiv_start_len got %0d exp 20", hi); else pass++;
        chk++; if (wb_valid !== 1'b1 || wb_data !== 32'h7F800000 || wb_err !== 1'b0)
            $display("FAIL fdiv_wb got valid=%b data=%h err=%b exp 1/7f800000/0", wb_valid, wb_data, wb_err); else pass++;
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk++; if (fflags !== 5'b01000) $display("FAIL fdiv_fflags got %b exp 01000", fflags); else pass++;
    endtask

    task automatic test_rm;
        frm = 3'b101;
        send(5'b00010, 3'b111, 32'h40000000, 32'h40000000, 5'd9);
        set_fu(1'b1, 32'h12345678, 5'b10000);
        chk++; if (fu_start !== 1'b0) $display("FAIL rm_bad_start got %b exp 0", fu_start); else pass++;
        chk++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 32'h0)
            $display("FAIL rm_bad_wb got valid=%b err=%b data=%h exp 1/1/0", wb_valid, wb_err, wb_data); else pass++;
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        set_fu(1'b0, 32'h0, 5'b0);
        chk++; if (fflags !== 5'b01000) $display("FAIL rm_bad_fflags got %b exp 01000", fflags); else pass++;
        frm = 3'b001;
        send(5'b00010, 3'b111, 32'h40000000, 32'h40000000, 5'd9);
        chk++; if (fu_start !== 1'b1 || fu_rm !== 3'b001) $display("FAIL rm_dyn got start=%b rm=%b exp 1/001", fu_start, fu_rm); else pass++;
        set_fu(1'b1, 32'h40800000, 5'b00001);
        @(negedge clk);
        set_fu(1'b0, 32'h0, 5'b0);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk++; if (fflags !== 5'b01001) $display("FAIL rm_dyn_fflags got %b exp 01001", fflags); else pass++;
        // Non-arithmetic op: rm passes through untouched and the result goes to the integer file.
        send(5'b10100, 3'b010, 32'h3F800000, 32'h3F800000, 5'd2);
        chk++; if (fu_rm !== 3'b010 || fu_start !== 1'b1) $display("FAIL cmp_rm got rm=%b start=%b exp 010/1", fu_rm, fu_start); else pass++;
        set_fu(1'b1, 32'h1, 5'b0);
        @(negedge clk);
        set_fu(1'b0, 32'h0, 5'b0);
        chk++; if (wb_to_int !== 1'b1 || wb_data !== 32'h1) $display("FAIL cmp_wb got int=%b data=%h exp 1/1", wb_to_int, wb_data); else pass++;
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int bad = 0;
        send(5'b00010, 3'b000, 32'h00800000, 32'h00800000, 5'd17);
        set_fu(1'b1, 32'h00000001, 5'b00010);
        @(negedge clk);
        set_fu(1'b0, 32'h0, 5'b0);
        for (int i = 0; i < 5; i++) begin
            if (wb_valid !== 1'b1 || wb_data !== 32'h1 || wb_rd !== 5'd17 || req_ready !== 1'b0 || fflags !== 5'b01001) bad++;
            @(negedge clk);
        end
        chk++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else pass++;
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk++; if (fflags !== 5'b01011 || wb_valid !== 1'b0) $display("FAIL bp_accrue got fflags=%b valid=%b exp 01011/0", fflags, wb_valid); else pass++;
    endtask

    task automatic test_reset_mid;
        send(5'b01011, 3'b000, 32'h40800000, 32'h0, 5'd4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk++; if (fu_start !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1 || fflags !== 5'b0)
            $display("FAIL rst_mid got start=%b valid=%b ready=%b fflags=%b exp 0/0/1/00000", fu_start, wb_valid, req_ready, fflags); else pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk++; if (fu_start !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_mid_idle got start=%b ready=%b exp 0/1", fu_start, req_ready); else pass++;
    endtask

    task automatic test_timeout;
        int hi = 0;
        int n = 0;
        fflags_we = 1'b1; fflags_wdata = 5'b10101;
        @(negedge clk);
        fflags_we = 1'b0;
        chk++; if (fflags !== 5'b10101) $display("FAIL csr_write got %b exp 10101", fflags); else pass++;
        send(5'b00000, 3'b000, 32'h1, 32'h2, 5'd5);
        while (!wb_valid && n < 200) begin
            if (fu_start) hi++;
            n++;
            @(negedge clk);
        end
        chk++; if (hi !== 64 || wb_valid !== 1'b1) $display("FAIL timeout_len got %0d valid=%b exp 64/1", hi, wb_valid); else pass++;
        chk++; if (wb_err !== 1'b1 || wb_data !== 32'h0) $display("FAIL timeout_err got err=%b data=%h exp 1/0", wb_err, wb_data); else pass++;
        wb_ready = 1'b1; fflags_we = 1'b1; fflags_wdata = 5'b0;
        @(negedge clk);
        wb_ready = 1'b0; fflags_we = 1'b0;
        chk++; if (fflags !== 5'b0) $display("FAIL timeout_csr got %b exp 00000", fflags); else pass++;
        // CSR write in the handshake cycle swallows that op's accrual.
        send(5'b00001, 3'b000, 32'h3F800000, 32'h3F800000, 5'd6);
        set_fu(1'b1, 32'h0, 5'b00001);
        @(negedge clk);
        set_fu(1'b0, 32'h0, 5'b0);
        wb_ready = 1'b1; fflags_we = 1'b1; fflags_wdata = 5'b00010;
        @(negedge clk);
        wb_ready = 1'b0; fflags_we = 1'b0;
        chk++; if (fflags !== 5'b00010) $display("FAIL csr_over_accrue got %b exp 00010", fflags); else pass++;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_op = '0; req_rm = '0; req_rs2_lsb = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
        frm = 3'b000; wb_ready = 1'b0; fflags_we = 1'b0; fflags_wdata = '0;
        set_fu(1'b0, 32'h0, 5'b0);
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b1;
        @(negedge clk);
        test_fadd;
        test_fdiv;
        test_rm;
        test_backpressure;
        test_reset_mid;
        test_timeout;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
